// File: rtl/fft16_block.sv
// 16-point radix-2 DIT complex FFT, serial in / serial out; output bins equal DFT/16.
// Define FFT_ROUND_EN for round-half-up on every right shift. The default build truncates.
module fft16_block #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic signed [DATA_W-1:0] x_r,
  input  logic signed [DATA_W-1:0] x_i,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] X_r,
  output logic signed [DATA_W-1:0] X_i
);

  // state   | meaning
  // LOAD    | accept one sample per cycle into its bit-reversed slot
  // COMPUTE | run one butterfly stage per cycle, stages 0..3
  // UNLOAD  | present one bin per cycle in natural order
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  localparam int PW = DATA_W + TW_W + 1;  // full-precision complex product
  localparam int TT = DATA_W + 2;         // twiddled operand after rescale
  localparam int SW = DATA_W + 3;         // butterfly sum before halving

`ifdef FFT_ROUND_EN
  localparam logic signed [PW-1:0] PROD_HALF  = PW'(1) <<< (TW_W - 3);
  localparam logic signed [SW-1:0] STAGE_HALF = SW'(1);
`endif

  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [1:0] stage;
  logic       load_en, comp_en, unload_en;

  logic signed [DATA_W-1:0] mem_r [16];
  logic signed [DATA_W-1:0] mem_i [16];
  logic signed [DATA_W-1:0] nxt_r [16];
  logic signed [DATA_W-1:0] nxt_i [16];

  logic [3:0]               bf_top [8];
  logic [3:0]               bf_bot [8];
  logic signed [TW_W-1:0]   bf_wr  [8];
  logic signed [TW_W-1:0]   bf_wi  [8];
  logic signed [DATA_W-1:0] bf_pr  [8];
  logic signed [DATA_W-1:0] bf_pi  [8];
  logic signed [DATA_W-1:0] bf_qr  [8];
  logic signed [DATA_W-1:0] bf_qi  [8];

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Butterfly j of stage s: top = group*2*span + pos, bottom = top + span.
  function automatic logic [3:0] top_index(input logic [2:0] j, input logic [1:0] s);
    logic [3:0] jj;
    logic [3:0] mask;
    jj   = {1'b0, j};
    mask = (4'd1 << s) - 4'd1;
    return ((jj >> s) << (3'(s) + 3'd1)) | (jj & mask);
  endfunction

  function automatic logic [2:0] tw_index(input logic [2:0] j, input logic [1:0] s);
    logic [2:0] mask;
    mask = 3'((4'd1 << s) - 4'd1);
    return (j & mask) << (2'd3 - s);
  endfunction

  // ROM held at Q2.14 and widened by left shift, so TW_W must be at least 16.
  function automatic void twiddle(input logic [2:0] k,
                                  output logic signed [TW_W-1:0] w_r,
                                  output logic signed [TW_W-1:0] w_i);
    int c;
    int s;
    unique case (k)
      3'd0: begin c =  16384; s =      0; end
      3'd1: begin c =  15137; s =  -6270; end
      3'd2: begin c =  11585; s = -11585; end
      3'd3: begin c =   6270; s = -15137; end
      3'd4: begin c =      0; s = -16384; end
      3'd5: begin c =  -6270; s = -15137; end
      3'd6: begin c = -11585; s = -11585; end
      3'd7: begin c = -15137; s =  -6270; end
    endcase
    w_r = TW_W'(c <<< (TW_W - 16));
    w_i = TW_W'(s <<< (TW_W - 16));
  endfunction

  function automatic logic signed [TT-1:0] prod_shift(input logic signed [PW-1:0] v);
`ifdef FFT_ROUND_EN
    return TT'((v + PROD_HALF) >>> (TW_W - 2));
`else
    return TT'(v >>> (TW_W - 2));
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] stage_shift(input logic signed [SW-1:0] v);
`ifdef FFT_ROUND_EN
    return DATA_W'((v + STAGE_HALF) >>> 1);
`else
    return DATA_W'(v >>> 1);
`endif
  endfunction

  function automatic void butterfly(
    input  logic signed [DATA_W-1:0] a_r, a_i, b_r, b_i,
    input  logic signed [TW_W-1:0]   w_r, w_i,
    output logic signed [DATA_W-1:0] p_r, p_i, q_r, q_i
  );
    logic signed [TT-1:0] t_r;
    logic signed [TT-1:0] t_i;
    t_r = prod_shift(PW'(b_r) * PW'(w_r) - PW'(b_i) * PW'(w_i));
    t_i = prod_shift(PW'(b_r) * PW'(w_i) + PW'(b_i) * PW'(w_r));
    p_r = stage_shift(SW'(a_r) + SW'(t_r));
    p_i = stage_shift(SW'(a_i) + SW'(t_i));
    q_r = stage_shift(SW'(a_r) - SW'(t_r));
    q_i = stage_shift(SW'(a_i) - SW'(t_i));
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n)
      state <= LOAD;
    else if (!stall)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (cnt == 4'd15)  state_nxt = COMPUTE;
      COMPUTE: if (stage == 2'd3) state_nxt = UNLOAD;
      UNLOAD:  if (cnt == 4'd15)  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    load_en   = !rst_n && !stall && (state == LOAD);
    comp_en   = !rst_n && !stall && (state == COMPUTE);
    unload_en = !rst_n && !stall && (state == UNLOAD);
  end

  // All eight butterflies of the current stage, computed in place.
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      nxt_r[n] = mem_r[n];
      nxt_i[n] = mem_i[n];
    end
    for (int j = 0; j < 8; j++) begin
      bf_top[j] = top_index(3'(j), stage);
      bf_bot[j] = bf_top[j] | (4'd1 << stage);
      twiddle(tw_index(3'(j), stage), bf_wr[j], bf_wi[j]);
      butterfly(mem_r[bf_top[j]], mem_i[bf_top[j]], mem_r[bf_bot[j]], mem_i[bf_bot[j]],
                bf_wr[j], bf_wi[j], bf_pr[j], bf_pi[j], bf_qr[j], bf_qi[j]);
      nxt_r[bf_top[j]] = bf_pr[j];
      nxt_i[bf_top[j]] = bf_pi[j];
      nxt_r[bf_bot[j]] = bf_qr[j];
      nxt_i[bf_bot[j]] = bf_qi[j];
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_r[bitrev4(cnt)] <= x_r;
      mem_i[bitrev4(cnt)] <= x_i;
    end else if (comp_en) begin
      for (int n = 0; n < 16; n++) begin
        mem_r[n] <= nxt_r[n];
        mem_i[n] <= nxt_i[n];
      end
    end
  end

  // cnt wraps 15 -> 0 on leaving LOAD and UNLOAD, so it doubles as the unload index.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt       <= 4'd0;
      stage     <= 2'd0;
      valid_out <= 1'b0;
      X_r       <= '0;
      X_i       <= '0;
    end else begin
      if (load_en || unload_en)
        cnt <= cnt + 4'd1;
      if (comp_en)
        stage <= stage + 2'd1;
      if (load_en)
        valid_out <= 1'b0;
      if (unload_en) begin
        valid_out <= 1'b1;
        X_r       <= mem_r[cnt];
        X_i       <= mem_i[cnt];
      end
    end
  end

endmodule

// File: tb/tb_fft16_block.sv
// Self-checking bench for fft16_block: floating-point DFT/16 scoreboard with per-pattern tolerance.
module tb_fft16_block;
  localparam int DATA_W = 16;
  localparam int TW_W   = 16;
  localparam real PI    = 3.14159265358979;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     stall;
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] x_i;
  logic                     valid_out;
  logic signed [DATA_W-1:0] X_r;
  logic signed [DATA_W-1:0] X_i;

  int checks   = 0;
  int failures = 0;
  int in_r [16];
  int in_i [16];
  int exp_r_q [$];
  int exp_i_q [$];
  int tol_q   [$];

  always #5 clk = ~clk;

  fft16_block #(.DATA_W(DATA_W), .TW_W(TW_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .x_r       (x_r),
    .x_i       (x_i),
    .valid_out (valid_out),
    .X_r       (X_r),
    .X_i       (X_i)
  );

  function automatic int round_real(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  // X[k] = (1/16) * sum x[n] * exp(-j*2*pi*k*n/16)
  function automatic void push_expected(input int tol);
    real sr, si, ang;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = 2.0 * PI * real'(k * n) / 16.0;
        sr  = sr + real'(in_r[n]) * $cos(ang) + real'(in_i[n]) * $sin(ang);
        si  = si + real'(in_i[n]) * $cos(ang) - real'(in_r[n]) * $sin(ang);
      end
      exp_r_q.push_back(round_real(sr / 16.0));
      exp_i_q.push_back(round_real(si / 16.0));
      tol_q.push_back(tol);
    end
  endfunction

  task automatic run_frame(input string name, input int tol,
                           input int ld_stall_after, input int ld_stall_len,
                           input int ul_stall_after, input int ul_stall_len,
                           input int abort_after);
    int er, ei, et, dr, di, lat;
    logic signed [DATA_W-1:0] hold_r, hold_i;
    push_expected(tol);
    for (int n = 0; n < 16; n++) begin
      x_r   = DATA_W'(in_r[n]);
      x_i   = DATA_W'(in_i[n]);
      stall = 1'b0;
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (valid_out !== 1'b0) begin
          failures++;
          $display("FAIL %s frame_start_valid got %0b want 0", name, valid_out);
        end
      end
      if (n == ld_stall_after) begin
        for (int s = 0; s < ld_stall_len; s++) begin
          stall = 1'b1;
          x_r   = 16'sh5a5a;
          x_i   = -16'sh1234;
          @(negedge clk);
        end
        stall = 1'b0;
      end
    end
    x_r = '0;
    x_i = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (valid_out !== 1'b1 && lat < 40);
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL %s latency got %0d edges want 5", name, lat);
      if (valid_out !== 1'b1) begin
        exp_r_q.delete();
        exp_i_q.delete();
        tol_q.delete();
        return;
      end
    end
    for (int b = 0; b < 16; b++) begin
      if (b > 0) @(negedge clk);
      er = exp_r_q.pop_front();
      ei = exp_i_q.pop_front();
      et = tol_q.pop_front();
      checks++;
      if (valid_out !== 1'b1) begin
        failures++;
        $display("FAIL %s bin%0d_valid got %0b want 1", name, b, valid_out);
      end
      dr = int'(X_r) - er;
      di = int'(X_i) - ei;
      checks++;
      if (dr > et || dr < -et) begin
        failures++;
        $display("FAIL %s bin%0d_re got %0d want %0d+-%0d", name, b, X_r, er, et);
      end
      checks++;
      if (di > et || di < -et) begin
        failures++;
        $display("FAIL %s bin%0d_im got %0d want %0d+-%0d", name, b, X_i, ei, et);
      end
      if (b == abort_after) begin
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || X_r !== '0 || X_i !== '0) begin
          failures++;
          $display("FAIL %s abort_reset got v=%0b X=%0d,%0d want v=0 X=0,0",
                   name, valid_out, X_r, X_i);
        end
        exp_r_q.delete();
        exp_i_q.delete();
        tol_q.delete();
        return;
      end
      if (b == ul_stall_after) begin
        hold_r = X_r;
        hold_i = X_i;
        for (int s = 0; s < ul_stall_len; s++) begin
          stall = 1'b1;
          @(negedge clk);
          checks++;
          if (valid_out !== 1'b1 || X_r !== hold_r || X_i !== hold_i) begin
            failures++;
            $display("FAIL %s unload_stall_hold got v=%0b X=%0d,%0d want v=1 X=%0d,%0d",
                     name, valid_out, X_r, X_i, hold_r, hold_i);
          end
        end
        stall = 1'b0;
      end
    end
  endtask

  task automatic fill_random(input int amp);
    for (int n = 0; n < 16; n++) begin
      in_r[n] = int'($urandom_range(2 * amp)) - amp;
      in_i[n] = int'($urandom_range(2 * amp)) - amp;
    end
  endtask

  task automatic fill_tone();
    for (int n = 0; n < 16; n++) begin
      in_r[n] = round_real(1600.0 * $cos(2.0 * PI * real'(n) / 16.0));
      in_i[n] = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    x_r   = 16'sd999;
    x_i   = -16'sd999;
    for (int c = 0; c < 3; c++) begin
      stall = c[0];
      @(negedge clk);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got %0b want 0", valid_out);
    end
    checks++;
    if (X_r !== '0 || X_i !== '0) begin
      failures++;
      $display("FAIL reset_X got %0d,%0d want 0,0", X_r, X_i);
    end
    rst_n = 1'b0;
    stall = 1'b0;
    for (int n = 0; n < 16; n++) begin
      in_r[n] = 0;
      in_i[n] = 0;
    end
    run_frame("zero", 0, -1, 0, -1, 0, -1);
  endtask

  task automatic test_impulse();
    for (int n = 0; n < 16; n++) begin
      in_r[n] = (n == 0) ? 1600 : 0;
      in_i[n] = 0;
    end
    run_frame("impulse", 0, -1, 0, -1, 0, -1);
  endtask

  task automatic test_dc();
    for (int n = 0; n < 16; n++) begin
      in_r[n] = 1600;
      in_i[n] = 0;
    end
    run_frame("dc", 1, -1, 0, -1, 0, -1);
  endtask

  task automatic test_tone();
    fill_tone();
    run_frame("tone", 2, -1, 0, -1, 0, -1);
  endtask

  task automatic test_stall();
    fill_random(8000);
    run_frame("stall", 5, 7, 3, 4, 2, -1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_random(8000);
      run_frame("b2b", 5, -1, 0, -1, 0, -1);
    end
  endtask

  task automatic test_reset_mid_unload();
    fill_random(8000);
    run_frame("abort", 5, -1, 0, -1, 0, 5);
    fill_tone();
    run_frame("after_abort", 2, -1, 0, -1, 0, -1);
    x_r = '0;
    x_i = '0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL final_valid_drop got %0b want 0", valid_out);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    stall = 1'b0;
    x_r   = '0;
    x_i   = '0;
    test_reset();
    test_impulse();
    test_dc();
    test_tone();
    test_stall();
    test_back_to_back();
    test_reset_mid_unload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
